img_pattern_gen: RTL and testbench

- Synthesizable, parametrised image-sensor pattern generator that drives the sensor-side pixel bus (img_d/img_fv/img_lv) from the fabric clock.
- Lets capture/histogram logic be exercised on hardware and in simulation without a sensor.
- Adds over the earlier sim-only model: configurable geometry, pixel width and blanking; selectable patterns; start/stop control; bounded or continuous frame count; status outputs.

---
 rtl/img_pattern_gen.sv | 177 +++++++++++++++++
 tb/tb_img_pattern_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/img_pattern_gen.sv
// Image-sensor pattern generator: drives a synthetic pixel bus (img_d/img_fv/img_lv)
// with selectable test patterns, configurable geometry/blanking and frame-count control.
module img_pattern_gen #(
  parameter int unsigned ImgWidth   = 256,
  parameter int unsigned ImgHeight  = 256,
  parameter int unsigned PixelWidth = 12,
  parameter int unsigned FrontPorch = 6,
  parameter int unsigned LineBlank  = 6,
  parameter int unsigned FrameBlank = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [1:0]            cfg_mode,
  input  logic [PixelWidth-1:0] cfg_const,
  input  logic [7:0]            cfg_frames,
  output logic [PixelWidth-1:0] img_d,
  output logic                  img_fv,
  output logic                  img_lv,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned PixCntW  = $clog2(ImgWidth * ImgHeight) + 1;
  localparam int unsigned PhaseA   = (FrontPorch > ImgWidth) ? FrontPorch : ImgWidth;
  localparam int unsigned PhaseB   = (LineBlank > FrameBlank) ? LineBlank : FrameBlank;
  localparam int unsigned PhaseMax = (PhaseA > PhaseB) ? PhaseA : PhaseB;
  localparam int unsigned CntW     = $clog2(PhaseMax) + 2;
  localparam int unsigned RowW     = $clog2(ImgHeight) + 2;
  localparam int unsigned ExtW     = (PixCntW > PixelWidth) ? PixCntW : PixelWidth;

  typedef enum logic [2:0] {IDLE, FRONT, LINE, LBLANK, FBLANK} state_t;

  state_t                state, state_n;
  logic [CntW-1:0]       cnt, cnt_n;
  logic [RowW-1:0]       row, row_n;
  logic [PixCntW-1:0]    pix, pix_n;
  logic [7:0]            frame_cnt, frame_cnt_n;
  logic                  stop_q, stop_n;
  logic [1:0]            mode_q, mode_n;
  logic [PixelWidth-1:0] const_q, const_n;
  logic [7:0]            frames_q, frames_n;
  logic [PixelWidth-1:0] d_n;
  logic                  fv_n, lv_n, busy_n, done_n;
  logic [ExtW-1:0]       pix_ext;

  // Next-state, counters and next-cycle outputs; outputs are decoded from the
  // next state so the registered bus lines up with the state register.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    row_n       = row;
    pix_n       = pix;
    frame_cnt_n = frame_cnt;
    stop_n      = stop_q;
    mode_n      = mode_q;
    const_n     = const_q;
    frames_n    = frames_q;
    if (state != IDLE) stop_n = stop_q | stop;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_n     = FRONT;
          cnt_n       = '0;
          row_n       = '0;
          pix_n       = '0;
          frame_cnt_n = '0;
          mode_n      = cfg_mode;
          const_n     = cfg_const;
          frames_n    = cfg_frames;
          stop_n      = stop;
        end
      end
      FRONT: begin
        if (cnt == CntW'(FrontPorch - 1)) begin
          state_n = LINE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CntW'(1);
        end
      end
      LINE: begin
        pix_n = pix + PixCntW'(1);
        if (cnt == CntW'(ImgWidth - 1)) begin
          state_n = LBLANK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CntW'(1);
        end
      end
      LBLANK: begin
        if (cnt == CntW'(LineBlank - 1)) begin
          cnt_n = '0;
          if (row == RowW'(ImgHeight - 1)) begin
            state_n     = FBLANK;
            frame_cnt_n = frame_cnt + 8'd1;
          end else begin
            state_n = LINE;
            row_n   = row + RowW'(1);
          end
        end else begin
          cnt_n = cnt + CntW'(1);
        end
      end
      FBLANK: begin
        if (cnt == CntW'(FrameBlank - 1)) begin
          cnt_n = '0;
          if (stop_q || stop || (frames_q != 8'd0 && frame_cnt == frames_q)) begin
            state_n = IDLE;
            stop_n  = 1'b0;
          end else begin
            state_n = FRONT;
            row_n   = '0;
            pix_n   = '0;
            mode_n  = cfg_mode;
            const_n = cfg_const;
          end
        end else begin
          cnt_n = cnt + CntW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    fv_n    = (state_n == FRONT) || (state_n == LINE) || (state_n == LBLANK);
    lv_n    = (state_n == LINE);
    busy_n  = (state_n != IDLE);
    done_n  = (state_n == FBLANK) && (state != FBLANK);
    pix_ext = ExtW'(pix_n);
    d_n     = '0;
    if (lv_n) begin
      unique case (mode_n)
        2'd0: d_n = PixelWidth'(~pix_ext);
        2'd1: d_n = PixelWidth'(pix_ext);
        2'd2: d_n = (row_n[1:0] == 2'd0 && cnt_n[1:0] == 2'd0) ? '1 : '0;
        2'd3: d_n = const_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      row        <= '0;
      pix        <= '0;
      frame_cnt  <= '0;
      stop_q     <= 1'b0;
      mode_q     <= '0;
      const_q    <= '0;
      frames_q   <= '0;
      img_d      <= '0;
      img_fv     <= 1'b0;
      img_lv     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      row        <= row_n;
      pix        <= pix_n;
      frame_cnt  <= frame_cnt_n;
      stop_q     <= stop_n;
      mode_q     <= mode_n;
      const_q    <= const_n;
      frames_q   <= frames_n;
      img_d      <= d_n;
      img_fv     <= fv_n;
      img_lv     <= lv_n;
      busy       <= busy_n;
      frame_done <= done_n;
    end
  end

endmodule

// File: tb/tb_img_pattern_gen.sv
// Bench for img_pattern_gen: pixel scoreboard per instance plus cycle-exact
// frame timing checks on a small 4x2 instance and an 8x8 grid-pattern instance.
module tb_img_pattern_gen;

  localparam int PW      = 12;
  localparam int W0      = 4;
  localparam int H0      = 2;
  localparam int FP      = 6;
  localparam int LB      = 6;
  localparam int FB      = 6;
  localparam int Period0 = FP + H0 * (W0 + LB) + FB;
  localparam int W1      = 8;
  localparam int H1      = 8;
  localparam int Period1 = FP + H1 * (W1 + LB) + FB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          start1 = 1'b0;
  logic          stop = 1'b0;
  logic [1:0]    cfg_mode = 2'd0;
  logic [PW-1:0] cfg_const = '0;
  logic [7:0]    cfg_frames = 8'd1;
  logic [PW-1:0] d0, d1;
  logic          fv0, lv0, busy0, done0;
  logic          fv1, lv1, busy1, done1;

  int total = 0;
  int bad   = 0;
  logic [PW-1:0] q0[$];
  logic [PW-1:0] q1[$];

  always #5 clk = ~clk;

  img_pattern_gen #(
    .ImgWidth(W0), .ImgHeight(H0), .PixelWidth(PW),
    .FrontPorch(FP), .LineBlank(LB), .FrameBlank(FB)
  ) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_mode(cfg_mode), .cfg_const(cfg_const), .cfg_frames(cfg_frames),
    .img_d(d0), .img_fv(fv0), .img_lv(lv0), .busy(busy0), .frame_done(done0)
  );

  img_pattern_gen #(
    .ImgWidth(W1), .ImgHeight(H1), .PixelWidth(PW),
    .FrontPorch(FP), .LineBlank(LB), .FrameBlank(FB)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .stop(stop),
    .cfg_mode(cfg_mode), .cfg_const(cfg_const), .cfg_frames(cfg_frames),
    .img_d(d1), .img_fv(fv1), .img_lv(lv1), .busy(busy1), .frame_done(done1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] pix_val(input logic [1:0] m, input int idx,
                                            input int r, input int c, input logic [PW-1:0] k);
    logic [PW-1:0] v;
    case (m)
      2'd0: v = ~PW'(idx);
      2'd1: v = PW'(idx);
      2'd2: v = (r % 4 == 0 && c % 4 == 0) ? '1 : '0;
      default: v = k;
    endcase
    return v;
  endfunction

  task automatic push_frame(input bit which, input logic [1:0] m, input logic [PW-1:0] k,
                            input int w, input int h);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        if (which) q1.push_back(pix_val(m, r * w + c, r, c, k));
        else       q0.push_back(pix_val(m, r * w + c, r, c, k));
      end
  endtask

  // Scoreboard: every lv cycle consumes one expected pixel; blank cycles must carry 0.
  always @(posedge clk) begin
    #1;
    if (lv0) begin
      if (q0.size() == 0) check("q0_underrun", 32'(q0.size()), 32'd1);
      else                check("d0", 32'(d0), 32'(q0.pop_front()));
    end else begin
      check("d0_blank", 32'(d0), 32'd0);
    end
    if (lv1) begin
      if (q1.size() == 0) check("q1_underrun", 32'(q1.size()), 32'd1);
      else                check("d1", 32'(d1), 32'(q1.pop_front()));
    end else begin
      check("d1_blank", 32'(d1), 32'd0);
    end
  end

  // Drive a start in the current cycle (cycle 0).
  task automatic kick(input logic [1:0] m, input logic [PW-1:0] k, input logic [7:0] nf,
                      input logic stp);
    cfg_mode   = m;
    cfg_const  = k;
    cfg_frames = nf;
    start      = 1'b1;
    stop       = stp;
  endtask

  // Step cycles 1.. after a kick and check dut0 frame timing against n back-to-back frames.
  task automatic run_frames(input int n, input int stop_at, input int start_at, input int chg_at);
    for (int t = 1; t <= n * Period0 + 4; t++) begin
      int  p;
      bit  in_run, e_fv, e_lv, e_done;
      @(posedge clk);
      #1;
      start = (t == start_at);
      stop  = (t == stop_at);
      if (t == chg_at) cfg_mode = 2'd0;
      p      = (t - 1) % Period0;
      in_run = (t <= n * Period0);
      e_fv   = in_run && (p < FP + H0 * (W0 + LB));
      e_lv   = e_fv && (p >= FP) && ((p - FP) % (W0 + LB) < W0);
      e_done = in_run && (p == FP + H0 * (W0 + LB));
      check("fv", 32'(fv0), 32'(e_fv));
      check("lv", 32'(lv0), 32'(e_lv));
      check("busy", 32'(busy0), 32'(in_run));
      check("frame_done", 32'(done0), 32'(e_done));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_fv", 32'(fv0), 32'd0);
    check("rst_lv", 32'(lv0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_d", 32'(d0), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // single inverted-count frame, with a stray start while busy
    kick(2'd0, '0, 8'd1, 1'b0);
    push_frame(1'b0, 2'd0, '0, W0, H0);
    run_frames(1, -1, 12, -1);

    // continuous count mode, stop during the second frame
    kick(2'd1, '0, 8'd0, 1'b0);
    push_frame(1'b0, 2'd1, '0, W0, H0);
    push_frame(1'b0, 2'd1, '0, W0, H0);
    run_frames(2, 40, -1, -1);

    // grid pattern on the 8x8 instance
    cfg_mode   = 2'd2;
    cfg_frames = 8'd1;
    start1     = 1'b1;
    push_frame(1'b1, 2'd2, '0, W1, H1);
    for (int t = 1; t <= Period1 + 2; t++) begin
      @(posedge clk);
      #1;
      start1 = 1'b0;
      check("busy1", 32'(busy1), 32'(t <= Period1));
      check("done1", 32'(done1), 32'(t == Period1 - FB + 1));
    end

    // constant mode; mode change mid-frame only applies to the second frame
    kick(2'd3, 12'h5A5, 8'd2, 1'b0);
    push_frame(1'b0, 2'd3, 12'h5A5, W0, H0);
    push_frame(1'b0, 2'd0, '0, W0, H0);
    run_frames(2, -1, -1, 10);

    // reset during row 1, then a clean frame
    kick(2'd1, '0, 8'd1, 1'b0);
    push_frame(1'b0, 2'd1, '0, W0, H0);
    for (int t = 1; t <= 18; t++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (t == 18) rst = 1'b1;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_fv", 32'(fv0), 32'd0);
    check("mid_rst_lv", 32'(lv0), 32'd0);
    check("mid_rst_busy", 32'(busy0), 32'd0);
    check("mid_rst_d", 32'(d0), 32'd0);
    check("mid_rst_left", 32'(q0.size()), 32'd2);
    q0.delete();
    @(posedge clk);
    #1;
    kick(2'd0, '0, 8'd1, 1'b0);
    push_frame(1'b0, 2'd0, '0, W0, H0);
    run_frames(1, -1, -1, -1);

    // start and stop together in IDLE: exactly one frame even in continuous mode
    kick(2'd1, '0, 8'd0, 1'b1);
    push_frame(1'b0, 2'd1, '0, W0, H0);
    run_frames(1, -1, -1, -1);

    check("q0_left", 32'(q0.size()), 32'd0);
    check("q1_left", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
